// File: rtl/pong_game_ctrl_pkg.sv
// pong_game_ctrl_pkg: shared state encoding and countdown timer constants for the pong game
package pong_game_ctrl_pkg;
    localparam logic [1:0] NEWGAME = 2'b00;
    localparam logic [1:0] PLAY    = 2'b01;
    localparam logic [1:0] NEWBALL = 2'b10;
    localparam logic [1:0] OVER    = 2'b11;
    localparam int TIMER_W = 7;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = 7'd127;
endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// pong_game_ctrl_btn_edge: one-cycle press event on a rising edge of any paddle button
module pong_game_ctrl_btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    output logic       press
);
    logic [1:0] btn_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) btn_q <= 2'b00;
        else btn_q <= btn;
    assign press = |(btn & ~btn_q);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer FSM, ball counter, timer and score control pulses
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int BALLS = 3,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    btn,
    input  logic          refr_tick,
    input  logic          hit,
    input  logic          miss,
    input  logic          timer_up,
    output logic          timer_start,
    output logic          timer_tick,
    output logic          gra_still,
    output logic          score_inc,
    output logic          score_clr,
    output logic [BW-1:0] balls_left,
    output logic [1:0]    state
);
    localparam logic [BW-1:0] BALLS_FULL = BW'(BALLS);
    localparam logic [BW-1:0] BALLS_SERVE = BW'(BALLS - 1);
    logic          press;
    logic          guard;
    logic          up;
    logic          last_ball;
    logic [1:0]    state_next;
    logic [BW-1:0] balls_next;
    pong_game_ctrl_btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );
    assign timer_tick = refr_tick;
    // the timer reloads one edge after timer_start, so its timer_up is stale on the entry cycle
    assign up = timer_up & ~guard;
    assign last_ball = balls_left == '0;
    always_comb begin
        state_next = state;
        balls_next = balls_left;
        case (state)
            NEWGAME: begin
                state_next = press ? PLAY : NEWGAME;
                balls_next = press ? BALLS_SERVE : BALLS_FULL;
            end
            PLAY: begin
                state_next = miss ? (last_ball ? OVER : NEWBALL) : PLAY;
                balls_next = (miss && !last_ball) ? balls_left - 1'b1 : balls_left;
            end
            NEWBALL: state_next = (up && press) ? PLAY : NEWBALL;
            default: begin
                state_next = up ? NEWGAME : OVER;
                balls_next = up ? BALLS_FULL : balls_left;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= NEWGAME;
            balls_left  <= BALLS_FULL;
            gra_still   <= 1'b1;
            timer_start <= 1'b0;
            score_inc   <= 1'b0;
            score_clr   <= 1'b0;
            guard       <= 1'b0;
        end else begin
            state       <= state_next;
            balls_left  <= balls_next;
            gra_still   <= state_next != PLAY;
            timer_start <= state == PLAY && miss;
            score_inc   <= state == PLAY && hit && !miss;
            score_clr   <= state == NEWGAME && press;
            guard       <= state == PLAY && miss;
        end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: vector table plus timer-model sequences for the pong game sequencer
module tb_pong_game_ctrl;
    import pong_game_ctrl_pkg::*;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       tu_drv = 1'b0;
    logic       use_model = 1'b0;
    logic       timer_up;
    logic       timer_start, timer_tick, gra_still, score_inc, score_clr;
    logic [1:0] balls_left;
    logic [1:0] state;
    logic [TIMER_W-1:0] tcnt = '0;
    int checks = 0;
    int errors = 0;

    pong_game_ctrl #(.BALLS(3), .BW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .refr_tick   (refr_tick),
        .hit         (hit),
        .miss        (miss),
        .timer_up    (timer_up),
        .timer_start (timer_start),
        .timer_tick  (timer_tick),
        .gra_still   (gra_still),
        .score_inc   (score_inc),
        .score_clr   (score_clr),
        .balls_left  (balls_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    // reference countdown timer: reloads on timer_start, decrements per tick down to 0
    always @(posedge clk)
        if (timer_start) tcnt <= TIMER_LOAD;
        else if (timer_tick && tcnt != '0) tcnt <= tcnt - 1'b1;
    assign timer_up = use_model ? (tcnt == '0) : tu_drv;

    // btn | hit miss tup refr | st | bl | gra_still sinc sclr tstart
    typedef struct packed {
        logic [1:0] btn;
        logic       hit, miss, tup, refr;
        logic [1:0] st;
        logic [1:0] bl;
        logic       gs, sinc, sclr, tst;
    } vec_t;
    vec_t v [25];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_up(input int idx);
        int n = 0;
        while (!timer_up && n < 400) begin
            step();
            n++;
        end
        chk("timer_up_wait", idx, 8'(timer_up), 8'd1);
    endtask

    task automatic press_once;
        btn = 2'b01;
        step();
        btn = 2'b00;
    endtask

    initial begin
        v[0]  = {2'b01, 4'b0000, 2'd1, 2'd2, 4'b0010};
        v[1]  = {2'b01, 4'b0001, 2'd1, 2'd2, 4'b0000};
        v[2]  = {2'b00, 4'b1000, 2'd1, 2'd2, 4'b0100};
        v[3]  = {2'b00, 4'b0000, 2'd1, 2'd2, 4'b0000};
        v[4]  = {2'b00, 4'b1001, 2'd1, 2'd2, 4'b0100};
        v[5]  = {2'b00, 4'b1000, 2'd1, 2'd2, 4'b0100};
        v[6]  = {2'b00, 4'b0000, 2'd1, 2'd2, 4'b0000};
        v[7]  = {2'b10, 4'b0001, 2'd1, 2'd2, 4'b0000};
        v[8]  = {2'b00, 4'b1100, 2'd2, 2'd1, 4'b1001};
        v[9]  = {2'b01, 4'b0010, 2'd2, 2'd1, 4'b1000};
        v[10] = {2'b01, 4'b0011, 2'd2, 2'd1, 4'b1000};
        v[11] = {2'b00, 4'b1110, 2'd2, 2'd1, 4'b1000};
        v[12] = {2'b10, 4'b0010, 2'd1, 2'd1, 4'b0000};
        v[13] = {2'b00, 4'b0100, 2'd2, 2'd0, 4'b1001};
        v[14] = {2'b00, 4'b0000, 2'd2, 2'd0, 4'b1000};
        v[15] = {2'b01, 4'b0001, 2'd2, 2'd0, 4'b1000};
        v[16] = {2'b01, 4'b0010, 2'd2, 2'd0, 4'b1000};
        v[17] = {2'b00, 4'b0010, 2'd2, 2'd0, 4'b1000};
        v[18] = {2'b01, 4'b0010, 2'd1, 2'd0, 4'b0000};
        v[19] = {2'b00, 4'b0100, 2'd3, 2'd0, 4'b1001};
        v[20] = {2'b10, 4'b0010, 2'd3, 2'd0, 4'b1000};
        v[21] = {2'b10, 4'b0000, 2'd3, 2'd0, 4'b1000};
        v[22] = {2'b10, 4'b0011, 2'd0, 2'd3, 4'b1000};
        v[23] = {2'b10, 4'b0000, 2'd0, 2'd3, 4'b1000};
        v[24] = {2'b11, 4'b0000, 2'd1, 2'd2, 4'b0010};

        #12;
        chk("rst_state", 0, 8'(state), 8'(NEWGAME));
        chk("rst_balls", 0, 8'(balls_left), 8'd3);
        chk("rst_gra_still", 0, 8'(gra_still), 8'd1);
        chk("rst_pulses", 0, 8'({timer_start, score_inc, score_clr}), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            {btn, hit, miss, tu_drv, refr_tick} = {v[i].btn, v[i].hit, v[i].miss, v[i].tup, v[i].refr};
            #1;
            chk("timer_tick", i, 8'(timer_tick), 8'(v[i].refr));
            step();
            chk("state", i, 8'(state), 8'(v[i].st));
            chk("balls_left", i, 8'(balls_left), 8'(v[i].bl));
            chk("gra_still", i, 8'(gra_still), 8'(v[i].gs));
            chk("score_inc", i, 8'(score_inc), 8'(v[i].sinc));
            chk("score_clr", i, 8'(score_clr), 8'(v[i].sclr));
            chk("timer_start", i, 8'(timer_start), 8'(v[i].tst));
        end

        {btn, hit, miss, tu_drv, refr_tick} = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        use_model = 1'b1;
        refr_tick = 1'b1;

        press_once();
        chk("seq_play", 100, 8'(state), 8'(PLAY));
        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("seq_nb", 101, 8'(state), 8'(NEWBALL));
        chk("seq_nb_balls", 101, 8'(balls_left), 8'd1);
        chk("seq_nb_tstart", 101, 8'(timer_start), 8'd1);
        step();
        chk("seq_tstart_off", 102, 8'(timer_start), 8'd0);
        repeat (49) step();
        press_once();
        chk("seq_early_press", 103, 8'(state), 8'(NEWBALL));
        wait_up(104);
        press_once();
        chk("seq_serve", 105, 8'(state), 8'(PLAY));
        chk("seq_serve_balls", 105, 8'(balls_left), 8'd1);

        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("seq_nb2_balls", 106, 8'(balls_left), 8'd0);
        step();
        wait_up(107);
        press_once();
        chk("seq_serve2", 108, 8'(state), 8'(PLAY));

        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("seq_over", 109, 8'(state), 8'(OVER));
        chk("seq_over_tstart", 109, 8'(timer_start), 8'd1);
        chk("seq_over_balls", 109, 8'(balls_left), 8'd0);
        btn = 2'b01;
        step();
        wait_up(110);
        chk("seq_over_hold", 111, 8'(state), 8'(OVER));
        step();
        chk("seq_newgame", 112, 8'(state), 8'(NEWGAME));
        chk("seq_newgame_balls", 112, 8'(balls_left), 8'd3);
        chk("seq_newgame_still", 112, 8'(gra_still), 8'd1);
        repeat (3) step();
        chk("seq_held_btn", 113, 8'(state), 8'(NEWGAME));
        btn = 2'b00;
        step();
        press_once();
        chk("seq_restart", 114, 8'(state), 8'(PLAY));
        chk("seq_restart_balls", 114, 8'(balls_left), 8'd2);

        miss = 1'b1;
        step();
        miss = 1'b0;
        step();
        wait_up(115);
        press_once();
        chk("seq_pre_reset", 116, 8'(balls_left), 8'd1);
        hit = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 117, 8'(state), 8'(NEWGAME));
        chk("async_still", 117, 8'(gra_still), 8'd1);
        chk("async_balls", 117, 8'(balls_left), 8'd3);
        chk("async_pulses", 117, 8'({timer_start, score_inc, score_clr}), 8'd0);
        hit = 1'b0;
        step();
        chk("reset_hold_state", 118, 8'(state), 8'(NEWGAME));
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong datapath.
- Owns the NEWGAME/PLAY/NEWBALL/OVER state machine and the remaining-ball counter.
- Drives the 7-bit countdown timer's start/tick inputs and consumes its timer_up.
- Freezes graphics (gra_still) between rallies and issues score increment/clear pulses to the score counter.

Parameters:
- BALLS, 3, balls per game (1..3).
- BW, 2, width of balls_left.

Ports:
- clk  in  1  system clock
- reset  in  1  async reset
- btn  in  2  paddle buttons, level, synchronous to clk
- refr_tick  in  1  one-cycle pulse per frame (start of vsync)
- hit  in  1  one-cycle pulse: ball struck paddle
- miss  in  1  one-cycle pulse: ball passed paddle
- timer_up  in  1  countdown timer reached 0
- timer_start  out  1  one-cycle reload pulse to timer
- timer_tick  out  1  decrement strobe to timer
- gra_still  out  1  1 = graphics frozen
- score_inc  out  1  one-cycle score increment
- score_clr  out  1  one-cycle score clear
- balls_left  out  BW  balls remaining after the one in play
- state  out  2  current state encoding, for text overlay select

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - state = NEWGAME, balls_left = BALLS, gra_still = 1.
  - timer_start, score_inc, score_clr, timer_tick = 0.
  - btn_q = 0, guard = 0.
- Button press detect:
  - btn_q registers btn every cycle.
  - press = |(btn & ~btn_q), a one-cycle rising-edge event.
  - A held button never produces a second press.
- timer_tick = refr_tick, combinational pass-through in all states.
- State encoding: NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.
- All outputs other than timer_tick and state are registered: they assert the cycle after the causing event.
- Transitions on press, hit and miss are evaluated in the cycle the event is seen.
- NEWGAME:
  - gra_still = 1; balls_left held at BALLS.
  - On press: go to PLAY, balls_left <= BALLS-1, score_clr pulses 1 cycle.
- PLAY:
  - gra_still = 0.
  - On hit (no miss): score_inc pulses 1 cycle.
  - On miss with balls_left == 0: go to OVER, timer_start pulses.
  - On miss with balls_left != 0: go to NEWBALL, balls_left <= balls_left-1, timer_start pulses.
  - hit and miss in the same cycle: miss wins, no score_inc.
- NEWBALL:
  - gra_still = 1.
  - Leaves to PLAY only when timer_up = 1 AND press = 1 in the same cycle.
  - A press before expiry is discarded; a new press is required.
- OVER:
  - gra_still = 1.
  - On timer_up: go to NEWGAME, balls_left <= BALLS.
- Stale-timer guard:
  - guard is set for exactly the first cycle after entering NEWBALL or OVER.
  - While guard = 1, timer_up is ignored, since the timer reloads one edge after timer_start.
- Events in wrong states:
  - hit/miss outside PLAY: ignored.
  - press in PLAY or OVER: ignored.
- balls_left never wraps below 0; a decrement is only issued when it is nonzero.
- Reset mid-game: immediate return to NEWGAME with reset values. The timer resets independently.

Decomposition:
- Shared package holds:
  - state encoding localparams NEWGAME/PLAY/NEWBALL/OVER, which the text overlay also uses;
  - TIMER_W = 7 and TIMER_LOAD = 127.
- One natural sub-module: btn_edge (btn_q register + rising-edge OR-reduce).
- The FSM and ball counter stay in pong_game_ctrl.

Test Plan:
1. Reset, then press btn=01 for 1 cycle → state=PLAY next cycle, score_clr=1 for 1 cycle, balls_left=2, gra_still=0.
2. PLAY, hit pulse ×3 → exactly three 1-cycle score_inc pulses. Hit+miss in the same cycle → no score_inc, state=NEWBALL.
3. PLAY, miss with balls_left=2:
   - Expected: timer_start 1 cycle, state=NEWBALL, balls_left=1.
   - Drive a timer model at 127 ticks: press at tick 50 → stays NEWBALL.
   - Press after timer_up → PLAY.
4. Stale timer_up: enter NEWBALL with timer_up still 1 from a prior expiry, press on the entry cycle → remains NEWBALL.
5. Miss with balls_left=0 → OVER, timer_start pulse. After 127 refr_ticks timer_up=1 → NEWGAME, balls_left=3. A button held through OVER does not restart the game.
6. Reset asserted mid-PLAY with balls_left=1 → state=NEWGAME, gra_still=1, balls_left=3 asynchronously; no score or timer pulses.
